// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: shared defaults, write-side state encoding and the
// 9-bit FIFO entry layout used by frame_buf and frame_buf_ram.
package frame_buf_pkg;

  localparam int DEPTH_DEF   = 64;  // byte entries, power of two 16..256
  localparam int MIN_LEN_DEF = 2;   // shortest accepted frame in bytes

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_e;

  // One FIFO entry: frame-end marker plus payload byte.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_buf_ram.sv
// frame_buf_ram: simple dual-port DEPTH x 9 storage.
//   clk   - write and read clock
//   we    - write enable; wdata lands at waddr on the rising edge
//   raddr - read address, sampled every cycle
//   rdata - registered read data (contents of raddr before that edge)
// Contents are not reset.
module frame_buf_ram
  import frame_buf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buf.sv
// frame_buf: store-and-forward frame buffer. Ingress frames (contiguous
// rx_dv runs) are written speculatively and only made visible to the
// egress side once the whole frame has arrived and is at least MIN_LEN
// bytes long; frames that do not fit are dropped whole.
//   clk, rst_n          - clock, async active-low reset
//   rxd, rx_dv          - ingress byte / valid
//   out_data, out_last  - egress byte and end-of-frame marker
//   out_valid, out_ready- egress handshake
//   frm_cnt, drop_cnt   - saturating committed / dropped frame counters
//   overflow            - one-cycle pulse when a frame is dropped for space
module frame_buf
  import frame_buf_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int MIN_LEN = MIN_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] frm_cnt,
  output logic [15:0] drop_cnt,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] MIN_L = LW'(MIN_LEN);

  wr_state_e     state_q;
  logic [AW-1:0] wr_ptr_q, cmt_ptr_q, rd_ptr_q;
  logic [7:0]    hold_q;
  logic [LW-1:0] len_q;
  logic          rx_dv_q;
  logic          commit_q;
  logic [15:0]   frm_cnt_q, drop_cnt_q;
  logic          ovf_q;

  logic [AW-1:0] wr_nxt, raddr;
  logic          full, in_recv, runt, wr_en, ovf_drop, rd_fire;
  entry_t        wdata, rdata;

  // Full is judged against the read pointer before this cycle's read, so
  // a byte freed in the same cycle does not count yet.
  assign wr_nxt   = wr_ptr_q + 1'b1;
  assign full     = (wr_nxt == rd_ptr_q);
  assign in_recv  = (state_q == RECV);
  assign runt     = in_recv && !rx_dv && (len_q < MIN_L);
  // In RECV every cycle writes the held byte: mid-frame with last=0, or
  // at frame end (rx_dv low) with last=1.
  assign wr_en    = in_recv && !runt && !full;
  assign ovf_drop = in_recv && !runt && full;
  assign wdata    = '{last: ~rx_dv, data: hold_q};

  assign out_valid = (rd_ptr_q != cmt_ptr_q);
  assign rd_fire   = out_valid && out_ready;
  // Read address runs one ahead on a transfer so the registered RAM output
  // always holds the entry at rd_ptr_q; it stays put while stalled.
  assign raddr     = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign out_data  = out_valid ? rdata.data : 8'h00;
  assign out_last  = out_valid ? rdata.last : 1'b0;
  assign frm_cnt   = frm_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign overflow  = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
      len_q      <= '0;
      rx_dv_q    <= 1'b1;  // a frame already in flight at release is ignored
      commit_q   <= 1'b0;
      frm_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rx_dv_q  <= rx_dv;
      ovf_q    <= 1'b0;
      commit_q <= 1'b0;
      // Publish the frame one cycle after its last byte was written so the
      // registered RAM read sees that byte before out_valid rises.
      if (commit_q) cmt_ptr_q <= wr_ptr_q;
      if (rd_fire)  rd_ptr_q  <= rd_ptr_q + 1'b1;

      unique case (state_q)
        IDLE: begin
          if (rx_dv && !rx_dv_q) begin
            hold_q  <= rxd;
            len_q   <= LW'(1);
            state_q <= RECV;
          end
        end
        RECV: begin
          if (ovf_drop) begin
            wr_ptr_q   <= cmt_ptr_q;
            ovf_q      <= 1'b1;
            drop_cnt_q <= sat_inc(drop_cnt_q);
            // Frame already over: go straight to IDLE so a frame starting
            // next cycle is not swallowed by DROP.
            state_q    <= rx_dv ? DROP : IDLE;
          end else if (runt) begin
            wr_ptr_q   <= cmt_ptr_q;
            drop_cnt_q <= sat_inc(drop_cnt_q);
            state_q    <= IDLE;
          end else begin
            wr_ptr_q <= wr_nxt;
            if (rx_dv) begin
              hold_q <= rxd;
              if (len_q != '1) len_q <= len_q + 1'b1;
            end else begin
              commit_q  <= 1'b1;
              frm_cnt_q <= sat_inc(frm_cnt_q);
              state_q   <= IDLE;
            end
          end
        end
        DROP: begin
          if (!rx_dv) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  frame_buf_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

endmodule
